alu_pipe: RTL and testbench

//  Parametrised, handshaked, registered integer ALU; generational successor of our 4-bit registered ALU.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_seq.sv | 62 ++++++
 rtl/flop.sv | 21 ++
 rtl/alu_pipe.sv | 151 +++++++++++++++
 tb/tb_alu_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: operation codes, result flags and FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SHL = 3'd2,
        OP_SHR = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic err;
    } alu_flags_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    localparam int unsigned FLAG_BITS = $bits(alu_flags_t);

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits of A*B.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             active_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] acc_step;

    // The product of the final step is forwarded combinationally so the result
    // register can load on the same edge the last step would have been stored.
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product_o = acc_step;
    assign done_o    = active_i && (count_q == CNT_W'(WIDTH - 1));

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            count_d  = '0;
        end else if (active_i) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step;
            count_d  = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/flop.sv
// Generic enabled register with asynchronous active-low reset to zero.
module flop #(
    parameter int Bits = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [Bits-1:0] d,
    output logic [Bits-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked registered integer ALU with iterative multiply, illegal-op reporting
// and a sticky overflow flag; sits between issue and writeback.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_err,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam int RES_BITS = WIDTH + FLAG_BITS;

    typedef struct packed {
        alu_op_e          op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } alu_req_t;

    alu_req_t         req;
    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             sticky_q, sticky_d;
    logic             accept, take, is_mul, mul_start, mul_done, res_load;
    logic [WIDTH-1:0] mul_product, alu_res;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic             shift_oob;
    alu_flags_t       alu_flags, mul_flags, out_flags;
    logic [RES_BITS-1:0] res_d, res_q;

    assign req = '{op: alu_op_e'(in_op), a: in_a, b: in_b};

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid_q && out_ready;
    assign is_mul    = (req.op == OP_MUL) && MUL_EN;
    assign mul_start = accept && is_mul;
    assign res_load  = (accept && !is_mul) || mul_done;

    assign sum_ext   = {1'b0, req.a} + {1'b0, req.b};
    assign diff_ext  = {1'b0, req.a} - {1'b0, req.b};
    assign shift_oob = req.b >= WIDTH'(WIDTH);

    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        unique case (req.op)
            OP_ADD: begin
                alu_res         = sum_ext[WIDTH-1:0];
                alu_flags.carry = sum_ext[WIDTH];
                alu_flags.ovf   = (req.a[WIDTH-1] == req.b[WIDTH-1]) &&
                                  (alu_res[WIDTH-1] != req.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res         = diff_ext[WIDTH-1:0];
                alu_flags.carry = diff_ext[WIDTH];
                alu_flags.ovf   = (req.a[WIDTH-1] != req.b[WIDTH-1]) &&
                                  (alu_res[WIDTH-1] != req.a[WIDTH-1]);
            end
            OP_SHL: alu_res = shift_oob ? '0 : (req.a << req.b);
            OP_SHR: alu_res = shift_oob ? '0 : (req.a >> req.b);
            OP_AND: alu_res = req.a & req.b;
            OP_OR:  alu_res = req.a | req.b;
            OP_XOR: alu_res = req.a ^ req.b;
            // Only reaches the result register when the multiplier is not built.
            OP_MUL: alu_flags.err = 1'b1;
            default: alu_flags.err = 1'b1;
        endcase
        alu_flags.zero = !alu_flags.err && (alu_res == '0);
    end

    always_comb begin
        mul_flags      = '0;
        mul_flags.zero = (mul_product == '0);
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (reset),
        .start_i   (mul_start),
        .active_i  (state_q == ST_MUL),
        .a_i       (req.a),
        .b_i       (req.b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Acceptance of a MUL needs a free output slot, so a completing MUL never collides.
    assign res_d = mul_done ? {mul_flags, mul_product} : {alu_flags, alu_res};

    flop #(.Bits(RES_BITS)) u_res_reg (
        .clk   (clk),
        .rst_n (reset),
        .en    (res_load),
        .d     (res_d),
        .q     (res_q)
    );

    assign out_flags = alu_flags_t'(res_q[RES_BITS-1:WIDTH]);
    assign out_res   = res_q[WIDTH-1:0];
    assign out_zero  = out_flags.zero;
    assign out_carry = out_flags.carry;
    assign out_ovf   = out_flags.ovf;
    assign out_err   = out_flags.err;
    assign out_valid  = out_valid_q;
    assign ovf_sticky = sticky_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        sticky_d    = sticky_q;
        unique case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (take)     out_valid_d = 1'b0;
        if (res_load) out_valid_d = 1'b1;
        // A take of an overflowing result beats a simultaneous clear.
        if (clr_sticky)      sticky_d = 1'b0;
        if (take && out_ovf) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            sticky_q    <= sticky_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes model results on accept, monitor pops on take.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready, clr_sticky;
    logic [2:0]   in_op;
    logic [W-1:0] in_a, in_b, out_res;
    logic         out_zero, out_carry, out_ovf, out_err, ovf_sticky;

    logic         n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_clr_sticky;
    logic [2:0]   n_in_op;
    logic [W-1:0] n_in_a, n_in_b, n_out_res;
    logic         n_out_zero, n_out_carry, n_out_ovf, n_out_err, n_ovf_sticky;

    typedef struct {
        int res;
        bit zero;
        bit carry;
        bit ovf;
        bit err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   exp_sticky = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   rand_done;
    int   held;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_zero(out_zero), .out_carry(out_carry), .out_ovf(out_ovf), .out_err(out_err),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
    );

    alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .reset(reset),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_op(n_in_op), .in_a(n_in_a), .in_b(n_in_b),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_res(n_out_res),
        .out_zero(n_out_zero), .out_carry(n_out_carry), .out_ovf(n_out_ovf), .out_err(n_out_err),
        .ovf_sticky(n_ovf_sticky), .clr_sticky(n_clr_sticky)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference behaviour from plain integer arithmetic on 8-bit operands.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   s;
        e = '{res: 0, zero: 0, carry: 0, ovf: 0, err: 0};
        case (op)
            0: begin
                e.res   = (a + b) % 256;
                e.carry = (a + b) > 255;
                s       = to_signed(a) + to_signed(b);
                e.ovf   = (s > 127) || (s < -128);
            end
            1: begin
                e.res   = (a - b + 256) % 256;
                e.carry = a < b;
                s       = to_signed(a) - to_signed(b);
                e.ovf   = (s > 127) || (s < -128);
            end
            2: e.res = (b >= 8) ? 0 : (a * (2 ** b)) % 256;
            3: e.res = (b >= 8) ? 0 : a / (2 ** b);
            4: e.res = a & b;
            5: e.res = a | b;
            6: e.res = a ^ b;
            default: e.res = (a * b) % 256;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic send(input int op, input int a, input int b);
        int waited = 0;
        bit done = 1'b0;
        in_op    = 3'(op);
        in_a     = 8'(a);
        in_b     = 8'(b);
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(op, a, b));
                done = 1'b1;
            end else if (++waited > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", waited);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            exp_sticky = 1'b0;
        end else begin
            check("ovf_sticky", ovf_sticky, exp_sticky);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%0h expected no result", out_res);
                end else begin
                    mon_e = sb.pop_front();
                    check("res",   out_res,   mon_e.res);
                    check("zero",  out_zero,  mon_e.zero);
                    check("carry", out_carry, mon_e.carry);
                    check("ovf",   out_ovf,   mon_e.ovf);
                    check("err",   out_err,   mon_e.err);
                end
            end
            if (out_valid && out_ready && mon_e.ovf) exp_sticky = 1'b1;
            else if (clr_sticky)                     exp_sticky = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        out_ready = 1'b1; clr_sticky = 1'b0;
        n_in_valid = 1'b0; n_in_op = '0; n_in_a = '0; n_in_b = '0;
        n_out_ready = 1'b1; n_clr_sticky = 1'b0;
        mon_e = '{res: 0, zero: 0, carry: 0, ovf: 0, err: 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_res",   out_res, 0);
        check("rst_flags",     {out_zero, out_carry, out_ovf, out_err}, 0);
        check("rst_sticky",    ovf_sticky, 0);
        check("rst_in_ready",  in_ready, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ADD with carry-out, one-cycle latency
        send(0, 8'hF0, 8'h20);
        @(negedge clk);
        check("add_latency", out_valid, 1);
        @(posedge clk);
        #1;

        // signed overflow, sticky set, clear, then clear colliding with an overflow take
        send(0, 8'h7F, 8'h01);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sticky_set", ovf_sticky, 1);
        @(posedge clk);
        #1;
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_clr", ovf_sticky, 0);
        @(posedge clk);
        #1;
        send(0, 8'h7F, 8'h01);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_set_wins", ovf_sticky, 1);
        @(posedge clk);
        #1;

        // shift bounds, borrow, signed corner cases
        send(2, 8'h01, 8);
        send(3, 8'h80, 7);
        send(1, 8'h03, 8'h05);
        send(2, 8'h81, 7);
        send(3, 8'hFF, 8'hFF);
        send(0, 8'h80, 8'h80);
        send(1, 8'h80, 8'h01);
        send(4, 8'hA5, 8'h0F);
        send(6, 8'hFF, 8'hFF);
        drain("drain_directed");

        // multiply latency and busy window
        send(7, 13, 11);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("mul_busy_ready", in_ready, 0);
            check("mul_busy_valid", out_valid, 0);
        end
        @(negedge clk);
        check("mul_done_valid", out_valid, 1);
        @(posedge clk);
        #1;

        // MUL reported illegal when the multiplier is not built
        n_in_op = 3'd7; n_in_a = 8'd13; n_in_b = 8'd11; n_in_valid = 1'b1;
        @(negedge clk);
        check("nomul_ready", n_in_ready, 1);
        @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        @(negedge clk);
        check("nomul_valid", n_out_valid, 1);
        check("nomul_res",   n_out_res, 0);
        check("nomul_err",   n_out_err, 1);
        check("nomul_flags", {n_out_zero, n_out_carry, n_out_ovf}, 0);
        @(posedge clk);
        #1;

        // backpressure: first result held stable, later requests stall then drain in order
        drain("drain_pre_bp");
        out_ready = 1'b0;
        fork
            begin
                send(0, 8'h11, 8'h22);
                send(7, 8'hFF, 8'hFF);
                send(1, 8'h00, 8'h01);
                send(5, 8'h0C, 8'h30);
            end
            begin
                repeat (2) @(negedge clk);
                held = out_res;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_valid", out_valid, 1);
                    check("bp_hold",  out_res, held);
                    check("bp_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_bp");

        // randomized traffic with random backpressure and sticky clears
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    int op, a, b;
                    op = $urandom_range(0, 7);
                    a  = $urandom_range(0, 255);
                    b  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 255);
                    send(op, a, b);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready  = ($urandom_range(0, 3) != 0);
                    clr_sticky = ($urandom_range(0, 15) == 0);
                end
                out_ready  = 1'b1;
                clr_sticky = 1'b0;
            end
        join
        drain("drain_random");

        // reset during the fourth multiply cycle aborts it
        send(7, 5, 6);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_valid_in_rst", out_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", in_ready, 1);
        repeat (10) begin
            @(negedge clk);
            check("abort_no_result", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(0, 2, 2);
        drain("drain_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
